// File: rtl/bcd_pkg.sv
// Shared types and helpers for the three-digit BCD down-counter.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True when every nibble of a packed three-digit value is a legal BCD digit.
    function automatic logic is_bcd(input logic [11:0] value);
        return (value[11:8] <= BCD_MAX) && (value[7:4] <= BCD_MAX) && (value[3:0] <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of the borrow chain: subtracts borrow_in, wrapping 0 to 9.
module bcd_digit_dec
    import bcd_pkg::*;
(
    input  bcd_digit_t digit,
    input  logic       borrow_in,
    output bcd_digit_t digit_out,
    output logic       borrow_out
);

    always_comb begin
        digit_out  = digit;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit == 4'd0) begin
                digit_out  = BCD_MAX;
                borrow_out = 1'b1;
            end else begin
                digit_out  = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_decrementor.sv
// Three-digit BCD down-counter with load, optional auto-reload and sticky
// invalid-load flag.
module bcd_decrementor
    import bcd_pkg::*;
#(
    parameter bit RELOAD = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [11:0] bcd_in,
    input  logic        tick,
    output logic [3:0]  digit0,
    output logic [3:0]  digit1,
    output logic [3:0]  digit2,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_t      state;
    logic [11:0] reload_val;

    bcd_digit_t  dec0, dec1, dec2;
    logic        borrow0, borrow1, borrow2;
    logic        at_one;
    logic        load_ok;

    // Units always receive the borrow; the chain yields count-1 every cycle.
    bcd_digit_dec u_dec0 (
        .digit     (digit0),
        .borrow_in (1'b1),
        .digit_out (dec0),
        .borrow_out(borrow0)
    );

    bcd_digit_dec u_dec1 (
        .digit     (digit1),
        .borrow_in (borrow0),
        .digit_out (dec1),
        .borrow_out(borrow1)
    );

    bcd_digit_dec u_dec2 (
        .digit     (digit2),
        .borrow_in (borrow1),
        .digit_out (dec2),
        .borrow_out(borrow2)
    );

    assign at_one  = ({digit2, digit1, digit0} == 12'h001);
    assign load_ok = is_bcd(bcd_in);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            digit0     <= 4'd0;
            digit1     <= 4'd0;
            digit2     <= 4'd0;
            reload_val <= 12'h000;
            err        <= 1'b0;
        end else if (load) begin
            if (load_ok) begin
                {digit2, digit1, digit0} <= bcd_in;
                reload_val               <= bcd_in;
                err                      <= 1'b0;
                state                    <= (bcd_in != 12'h000) ? ST_RUN : ST_DONE;
            end else begin
                {digit2, digit1, digit0} <= 12'h000;
                err                      <= 1'b1;
                state                    <= ST_IDLE;
            end
        end else if (tick && state == ST_RUN) begin
            if (at_one) begin
                if (RELOAD) begin
                    {digit2, digit1, digit0} <= reload_val;
                    state                    <= (reload_val != 12'h000) ? ST_RUN : ST_DONE;
                end else begin
                    {digit2, digit1, digit0} <= 12'h000;
                    state                    <= ST_DONE;
                end
            end else if (!borrow2) begin
                // A borrow out of hundreds means 000; never wrap to 999.
                digit0 <= dec0;
                digit1 <= dec1;
                digit2 <= dec2;
            end
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule

// File: doc/bcd_decrementor.md
BCD_DECREMENTOR -- requirements
Module: bcd_decrementor

Interface
REQ-001 Parameter: RELOAD, default 0, 1 = on reaching 000 reload the last loaded value and keep counting.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 load  input  1  single-cycle request to capture bcd_in.
REQ-005 bcd_in  input  12  three packed BCD digits: [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-006 tick  input  1  decrement request, one per asserted cycle.
REQ-007 digit0 / digit1 / digit2  output  4 each  registered units / tens / hundreds of the current count.
REQ-008 busy  output  1  high in RUN.
REQ-009 done  output  1  high in DONE.
REQ-010 err  output  1  sticky flag: last load attempt held a non-BCD digit.

Function
REQ-011 FSM states SHALL be IDLE, RUN and DONE, one-hot or binary at implementer's choice.
REQ-012 A load is valid only if every nibble of bcd_in is <= 9.
REQ-013 Valid load, any state: next cycle digits = bcd_in and err = 0; go to RUN if the value is nonzero, else DONE; the reload register takes bcd_in.
REQ-014 Invalid load, any state: next cycle digits = 000, err = 1, state = IDLE; the reload register is unchanged.
REQ-015 In RUN, tick with no load: the count SHALL drop by exactly 1 in BCD the next cycle.
REQ-016 Decrement rule: units 0 -> 9 with borrow, else units-1; tens and hundreds likewise, each only when it receives a borrow.
REQ-017 Decrement latency SHALL be one cycle, tick to updated digits.
REQ-018 A tick that takes the count from 001 to 000 SHALL set state DONE in the same cycle the digits show 000 (RELOAD = 0).
REQ-019 With RELOAD = 1, a tick at 001 SHALL load the reload register into the digits and stay in RUN.
  - If the reload value is 000, go to DONE.
REQ-020 The count SHALL never wrap below 000; ticks in IDLE or DONE are ignored and the digits hold.
REQ-021 load and tick in the same cycle: load wins and the tick is discarded.
REQ-022 Consecutive ticks on every cycle SHALL each decrement once; there is no rate limit.
REQ-023 busy and done SHALL be decoded from the state register only, never from inputs.

Reset
REQ-024 While reset is high: state = IDLE, digits = 000, reload register = 000, busy = 0, done = 0, err = 0, independent of clk.
REQ-025 reset asserted mid-count SHALL abandon the count; after deassertion the block waits in IDLE for a load.

Structure
REQ-026 Shared package bcd_pkg SHALL hold:
  - typedef bcd_digit_t (4-bit);
  - constant BCD_MAX = 9;
  - the FSM state enum type.
REQ-027 The single-digit borrow logic SHALL be a sub-module bcd_digit_dec (digit, borrow_in -> digit_out, borrow_out), instantiated three times in a chain.
REQ-028 There SHALL be exactly one always_ff for state, digits and flags, with asynchronous reset in its sensitivity list.

Verification
REQ-029 Load 0x100, then 1 tick -> next cycle digits 0,9,9; busy = 1.
REQ-030 Load 0x003, then 3 back-to-back ticks -> 002, 001, 000; done = 1 on the cycle showing 000; further ticks hold 000.
REQ-031 Load 0x1A5 -> digits 000, err = 1, state IDLE; then load 0x050 -> err = 0, digits 050, busy = 1.
REQ-032 During RUN at 042, assert load = 1 with bcd_in 0x777 and tick = 1 together -> next cycle 777; no decrement.
REQ-033 RELOAD = 1: load 0x002, 3 ticks -> 001, 002, 001; done stays 0.
REQ-034 Assert reset asynchronously between edges while at 315 -> outputs go to 0 before the next clk edge; after release, ticks leave the count at 000.
